// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins ties, but a fetch is forced through after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_flush,
  output logic        i_done,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [15:0] d_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_ERR} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             cancel_q, cancel_d;
  logic [15:0]      addr_q, addr_d;
  logic             wr_q, wr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [15:0]      i_rdata_q, i_rdata_d;
  logic [15:0]      d_rdata_q, d_rdata_d;

  logic d_misaligned;
  logic fetch_ok;
  logic starved;
  logic grant_d;
  logic grant_i;

  // A fetch raised together with its own flush is already stale, so it never competes.
  assign d_misaligned = d_req & d_addr[0];
  assign fetch_ok     = i_req & ~i_flush;
  assign starved      = (starve_q == LIMIT);
  assign grant_d      = d_req & ~d_addr[0] & ~(fetch_ok & starved);
  assign grant_i      = fetch_ok & ~d_misaligned & (~d_req | starved);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_D;
      starve_q  <= '0;
      cancel_q  <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      cancel_q  <= cancel_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (d_misaligned) begin
          state_d = S_ERR;
        end else if (grant_d || grant_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    starve_d  = starve_q;
    cancel_d  = cancel_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          owner_d = OWN_D;
          addr_d  = d_addr;
          wr_d    = d_wr;
          wdata_d = d_wdata;
        end else if (grant_i) begin
          owner_d = OWN_I;
          addr_d  = i_addr;
          wr_d    = 1'b0;
          wdata_d = '0;
        end
        if (grant_i || !i_req) begin
          starve_d = '0;
        end else if (grant_d && !starved) begin
          starve_d = starve_q + 1'b1;
        end
      end
      S_WAIT: begin
        // The memory cycle cannot be aborted; a redirect only hides the result.
        if (i_flush && (owner_q == OWN_I)) begin
          cancel_d = 1'b1;
        end
        if (mem_ack) begin
          if (owner_q == OWN_I) begin
            i_rdata_d = mem_rdata;
          end else if (!wr_q) begin
            d_rdata_d = mem_rdata;
          end
        end
      end
      S_RESP:  cancel_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == S_WAIT);
    mem_wr    = (state_q == S_WAIT) & wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_done    = (state_q == S_RESP) & (owner_q == OWN_I) & ~cancel_q;
    d_done    = (state_q == S_RESP) & (owner_q == OWN_D);
    d_err     = (state_q == S_ERR);
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
  end

endmodule
